pc_predict_unit: RTL
====================

# pc_predict_unit

Parametrised fetch-stage program counter with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It holds the fetch address driven to instruction memory and selects the next PC from four sources, in priority order: EX-stage flush redirect, branch redirect, ID-stage stall hold, and BTB prediction or sequential increment. EX trains it with resolved control-flow outcomes, and EX compares the per-PC prediction flag against the resolved outcome to detect mispredictions.

## Interface
- XLEN, 32, address width; must be at least 8.
- RESET_VECTOR, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.
- BTB_ENTRIES, 16, number of BTB entries; power of two, 2 to 256. IDX = log2(BTB_ENTRIES).

- clk  in  1  clock; all state updates on the rising edge.
- rst_  in  1  reset; synchronous, active-high.
- stall  in  1  from ID; hold the PC.
- flush  in  1  from EX; redirect to pc_flush (trap or mispredict recovery).
- pc_flush  in  XLEN  flush target.
- branch  in  1  redirect to pc_branch.
- pc_branch  in  XLEN  branch target.
- upd_valid  in  1  from EX; a resolved control-flow instruction is reported this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  resolved direction.
- upd_target  in  XLEN  resolved taken target.
- pc  out  XLEN  current fetch address, registered; to instr_mem.
- pred_taken  out  1  combinational; BTB predicts pc as a taken branch.
- pred_target  out  XLEN  combinational; predicted target, valid when pred_taken = 1.

## Operation
- Index = pc[IDX+1:2]. Tag = pc[XLEN-1:IDX+2]. Each entry holds a valid bit, a tag, a target (XLEN-2 bits, low 2 bits implied 0) and a 2-bit counter.
- Lookup is on the current pc. hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = the entry's target.
- Next-PC selection: flush gives pc_flush; else branch gives pc_branch; else stall gives pc; else pred_taken gives pred_target; else pc + 4, modulo 2^XLEN (wraps from all-ones-minus-3 to 0).
- Bits [1:0] of every loaded target (pc_flush, pc_branch, upd_target) are forced to 0.
- BTB update happens when upd_valid = 1, independent of stall, flush and branch:
  - Tag hit, taken: counter increments, saturating at 11; the target is overwritten.
  - Tag hit, not taken: counter decrements, saturating at 00; the target is unchanged.
  - Miss, taken: the entry is allocated (valid = 1, new tag, new target, counter = 10), replacing any previous occupant.
  - Miss, not taken: no change.
- Reset: pc = RESET_VECTOR and all valid bits are cleared. Target and counter contents are don't-care. pred_taken = 0 immediately after reset.

## Timing
- pc changes one cycle after the select inputs are sampled. There is no bubble on a redirect: the cycle after flush, pc = pc_flush.
- pred_taken and pred_target are combinational from pc and BTB state, with zero latency.
- A BTB write takes effect at the edge. A lookup in the same cycle as a write to the same index sees the old contents. The prediction changes from the next cycle.
- flush and branch in the same cycle: flush wins. flush or branch during stall: the redirect wins.
- rst_ asserted mid-operation overrides all inputs, including a concurrent upd_valid. The BTB is empty afterwards.

## Configuration
- PC_BTB_EN defined: the BTB is built as described above.
- PC_BTB_EN undefined: no BTB storage is built. pred_taken is tied to 0, pred_target is tied to 0, and the upd_* inputs are ignored. Next PC becomes flush > branch > stall > pc + 4.

## Test plan
- Reset with RESET_VECTOR = 32'h0000_1000, then 3 idle cycles → pc = 0x1000, 0x1004, 0x1008, 0x100C; pred_taken = 0 throughout.
- Hold stall for 2 cycles at pc 0x08, assert flush = 1 with pc_flush = 0x200 together with branch = 1 and pc_branch = 0x300 → pc stays 0x08 during the stall, then pc = 0x200 after the redirect.
- Send upd_valid with upd_pc = 0x40, upd_taken = 1, upd_target = 0x100. Then flush to 0x40 → pred_taken = 1 and pred_target = 0x100 while pc = 0x40; the next pc = 0x100.
- Two not-taken updates for 0x40 (counter 10 → 01 → 00), then flush to 0x40 → pred_taken = 0; the next pc = 0x44.
- With BTB_ENTRIES = 16, train 0x40 taken, then flush to 0x80 (same index, different tag) → pred_taken = 0; next pc = 0x84. Then train 0x80 taken to 0x300 → the entry for 0x40 is evicted.
- Train 0x40 taken, assert rst_ for 1 cycle, then flush to 0x40 → pred_taken = 0. Build with PC_BTB_EN undefined and repeat the training test → pred_taken is always 0.

Source files
------------

// File: rtl/pc_predict_unit.sv
// Fetch-stage PC register with direct-mapped BTB and 2-bit direction counters.
// Define PC_BTB_EN to build the BTB; without it prediction is off and pc steps by 4.
module pc_predict_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BTB_ENTRIES  = 16
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_flush,
    input  logic            branch,
    input  logic [XLEN-1:0] pc_branch,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);
    localparam int              IDX    = $clog2(BTB_ENTRIES);
    localparam int              TAG_W  = XLEN - IDX - 2;
    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    logic [XLEN-1:0] pc_next;

`ifdef PC_BTB_EN
    logic [BTB_ENTRIES-1:0] valid;
    logic [TAG_W-1:0]       tag_mem [BTB_ENTRIES];
    logic [XLEN-3:0]        tgt_mem [BTB_ENTRIES];
    logic [1:0]             ctr_mem [BTB_ENTRIES];

    logic [IDX-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic             unused_bits;

    assign lk_idx = pc[IDX+1:2];
    assign lk_tag = pc[XLEN-1:IDX+2];
    assign up_idx = upd_pc[IDX+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX+2];

    assign lk_hit = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign up_hit = valid[up_idx] && (tag_mem[up_idx] == up_tag);

    assign pred_taken  = lk_hit && ctr_mem[lk_idx][1];
    assign pred_target = {tgt_mem[lk_idx], 2'b00};

    assign unused_bits = ^{pc_flush[1:0], pc_branch[1:0], upd_pc[1:0], upd_target[1:0]};

    // Only the valid bits need reset; a taken update either keeps a hit
    // entry valid or allocates a fresh one.
    always_ff @(posedge clk) begin
        if (rst_)
            valid <= '0;
        else if (upd_valid && upd_taken)
            valid[up_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_ && upd_valid) begin
            if (upd_taken) begin
                tag_mem[up_idx] <= up_tag;
                tgt_mem[up_idx] <= upd_target[XLEN-1:2];
                if (!up_hit)
                    ctr_mem[up_idx] <= 2'b10;
                else if (ctr_mem[up_idx] != 2'b11)
                    ctr_mem[up_idx] <= ctr_mem[up_idx] + 2'd1;
            end else if (up_hit && ctr_mem[up_idx] != 2'b00) begin
                ctr_mem[up_idx] <= ctr_mem[up_idx] - 2'd1;
            end
        end
    end
`else
    logic unused_bits;

    assign pred_taken  = 1'b0;
    assign pred_target = '0;
    assign unused_bits = ^{pc_flush[1:0], pc_branch[1:0], upd_valid, upd_pc,
                           upd_taken, upd_target};
`endif

    // Redirects beat stall so a trap or mispredict is never lost behind a hold.
    always_comb begin
        pc_next = pc + PC_INC;
        if (flush)
            pc_next = {pc_flush[XLEN-1:2], 2'b00};
        else if (branch)
            pc_next = {pc_branch[XLEN-1:2], 2'b00};
        else if (stall)
            pc_next = pc;
        else if (pred_taken)
            pc_next = pred_target;
    end

    always_ff @(posedge clk) begin
        if (rst_)
            pc <= RESET_VECTOR;
        else
            pc <= pc_next;
    end

endmodule
